// File: rtl/ase_pkg.sv
// ase_pkg
// Shared ASE types and defaults used by the UMsg path.
//   UMsg_StateEnum : per-ID UMsg delivery state
//   UMsgHdr_t      : 28-bit RX0 UMsg response header
//   umsg_t         : per-ID bookkeeping flags kept alongside the FSM
//   make_umsg_hdr  : builds a UMsg response header for a given ID / kind

`ifndef UMSG_DELAY_TIMER_LOG2
`define UMSG_DELAY_TIMER_LOG2 4
`endif

package ase_pkg;

  localparam int NUM_UMSG_PER_AFU      = 8;
  localparam int CCIP_DATA_WIDTH       = 512;
  localparam int UMSG_DELAY_TIMER_LOG2 = `UMSG_DELAY_TIMER_LOG2;
  localparam int ASE_UMSG_HINT_DELAY   = 4;
  localparam int ASE_UMSG_DATA_DELAY   = 8;

  localparam logic [3:0] CCIP_UMSG = 4'hF;

  typedef enum logic [2:0] {
    UMsgIdle,
    UMsgHintWait,
    UMsgSendHint,
    UMsgDataWait,
    UMsgSendData
  } UMsg_StateEnum;

  // RX0 UMsg header: 6+1+1+4+1+1+8+6 = 28 bits
  typedef struct packed {
    logic [5:0] rsvd_27_22;
    logic       poison;
    logic       rsvd_20;
    logic [3:0] resp_type;
    logic       rsvd_15;
    logic       umsg_type;
    logic [7:0] rsvd_13_6;
    logic [5:0] umsg_id;
  } UMsgHdr_t;

  // Timers live next to this struct in the engine because their width is
  // a parameter of the engine, not of the package.
  typedef struct packed {
    logic line_accessed;
    logic hint_enable;
  } umsg_t;

  function automatic UMsgHdr_t make_umsg_hdr(input logic [5:0] id, input logic is_hint);
    UMsgHdr_t h;
    h           = '0;
    h.resp_type = CCIP_UMSG;
    h.umsg_type = is_hint;
    h.umsg_id   = id;
    return h;
  endfunction

endpackage

// File: rtl/ase_rr_arbiter.sv
// ase_rr_arbiter
// Round-robin arbiter with a one-hot grant. The search starts one past the
// most recently granted requester; after reset the pointer sits at N-1 so
// requester 0 has first priority.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   grant_en   : when low no grant is issued and the pointer holds
//   grant      : one-hot grant (all zero when nothing is granted)

module ase_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         grant_en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] win_idx;
  logic          found;

  // Walk the requesters starting at last_q+1 and take the first one set.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = last_q;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last_q) + k) % N]) begin
        found   = 1'b1;
        win_idx = PW'((int'(last_q) + k) % N);
      end
    end
    if (grant_en && found) begin
      grant[win_idx] = 1'b1;
    end
  end

  // Remember the winner so it drops to lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PW'(N - 1);
    end else if (|grant) begin
      last_q <= win_idx;
    end
  end

endmodule

// File: rtl/ase_umsg_engine.sv
// ase_umsg_engine
// Per-ID UMsg delivery engine. Each UMsg ID runs its own small FSM that
// optionally waits/sends a hint and then waits/sends the data line. A
// round-robin arbiter picks among IDs ready to send and feeds one registered
// RX0 output slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/id/hint/data, cmd_ready : UMsg command in (never stalled)
//   umsg_valid/hdr/data, umsg_ready   : RX0 UMsg response out
//   busy                : any ID active or a response pending in the slot

module ase_umsg_engine
  import ase_pkg::*;
#(
  parameter int NUM_UMSG   = NUM_UMSG_PER_AFU,
  parameter int TIMER_W    = UMSG_DELAY_TIMER_LOG2,
  parameter int HINT_DELAY = ASE_UMSG_HINT_DELAY,
  parameter int DATA_DELAY = ASE_UMSG_DATA_DELAY
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  input  logic [$clog2(NUM_UMSG)-1:0]   cmd_id,
  input  logic                          cmd_hint,
  input  logic [CCIP_DATA_WIDTH-1:0]    cmd_data,
  output logic                          cmd_ready,
  output logic                          umsg_valid,
  output logic [27:0]                   umsg_hdr,
  output logic [CCIP_DATA_WIDTH-1:0]    umsg_data,
  input  logic                          umsg_ready,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_UMSG);
  localparam logic [TIMER_W-1:0] HINT_LOAD = TIMER_W'(HINT_DELAY);
  localparam logic [TIMER_W-1:0] DATA_LOAD = TIMER_W'(DATA_DELAY);

  UMsg_StateEnum        state_q      [NUM_UMSG];
  UMsg_StateEnum        state_d      [NUM_UMSG];
  logic [TIMER_W-1:0]   hint_timer_q [NUM_UMSG];
  logic [TIMER_W-1:0]   hint_timer_d [NUM_UMSG];
  logic [TIMER_W-1:0]   data_timer_q [NUM_UMSG];
  logic [TIMER_W-1:0]   data_timer_d [NUM_UMSG];
  umsg_t                ctl_q        [NUM_UMSG];
  umsg_t                ctl_d        [NUM_UMSG];
  logic [CCIP_DATA_WIDTH-1:0] data_buf [NUM_UMSG];

  logic [NUM_UMSG-1:0] cmd_hit;
  logic [NUM_UMSG-1:0] fresh;
  logic [NUM_UMSG-1:0] hint_ready;
  logic [NUM_UMSG-1:0] data_ready;
  logic [NUM_UMSG-1:0] grant;
  logic [NUM_UMSG-1:0] hint_pop;
  logic [NUM_UMSG-1:0] data_pop;
  logic [ID_W-1:0]     grant_id;
  logic                grant_is_hint;
  logic                grant_en;
  logic                any_active;

  // Commands are never back-pressured; ready simply mirrors reset.
  assign cmd_ready = rst_n;
  assign busy      = any_active | umsg_valid;

  // Per-ID state, timers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i]      <= UMsgIdle;
        hint_timer_q[i] <= '0;
        data_timer_q[i] <= '0;
        ctl_q[i]        <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i]      <= state_d[i];
        hint_timer_q[i] <= hint_timer_d[i];
        data_timer_q[i] <= data_timer_d[i];
        ctl_q[i]        <= ctl_d[i];
      end
    end
  end

  // Line storage is not reset; every ID writes its line before it can send.
  always_ff @(posedge clk) begin
    if (cmd_valid) begin
      data_buf[cmd_id] <= cmd_data;
    end
  end

  // Next-state logic. A command to an active ID only refreshes the line
  // (coalescing). A command landing on the cycle its ID's data is granted
  // restarts the FSM as if the ID were already idle.
  always_comb begin
    fresh = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i]      = state_q[i];
      hint_timer_d[i] = hint_timer_q[i];
      data_timer_d[i] = data_timer_q[i];
      ctl_d[i]        = ctl_q[i];
      case (state_q[i])
        UMsgIdle: fresh[i] = cmd_hit[i];
        UMsgHintWait: begin
          if (hint_timer_q[i] == '0) state_d[i] = UMsgSendHint;
          else hint_timer_d[i] = hint_timer_q[i] - 1'b1;
        end
        UMsgSendHint: begin
          if (hint_pop[i]) begin
            state_d[i]      = UMsgDataWait;
            data_timer_d[i] = DATA_LOAD;
          end
        end
        UMsgDataWait: begin
          if (data_timer_q[i] == '0) state_d[i] = UMsgSendData;
          else data_timer_d[i] = data_timer_q[i] - 1'b1;
        end
        UMsgSendData: begin
          if (data_pop[i]) begin
            state_d[i] = UMsgIdle;
            ctl_d[i]   = '0;
            fresh[i]   = cmd_hit[i];
          end
        end
        default: state_d[i] = UMsgIdle;
      endcase
      if (cmd_hit[i]) ctl_d[i].line_accessed = 1'b1;
      if (fresh[i]) begin
        if (cmd_hint) begin
          ctl_d[i].hint_enable = 1'b1;
          hint_timer_d[i]      = HINT_LOAD;
          state_d[i]           = UMsgHintWait;
        end else begin
          data_timer_d[i] = DATA_LOAD;
          state_d[i]      = UMsgDataWait;
        end
      end
    end
  end

  // FSM outputs: send requests, pops from the grant, winner encoding.
  always_comb begin
    any_active    = 1'b0;
    grant_id      = '0;
    grant_is_hint = 1'b0;
    grant_en      = !umsg_valid | umsg_ready;
    for (int i = 0; i < NUM_UMSG; i++) begin
      cmd_hit[i]    = cmd_valid && (cmd_id == ID_W'(i));
      hint_ready[i] = (state_q[i] == UMsgSendHint);
      data_ready[i] = (state_q[i] == UMsgSendData);
      hint_pop[i]   = grant[i] & hint_ready[i];
      data_pop[i]   = grant[i] & data_ready[i];
      if (state_q[i] != UMsgIdle) any_active = 1'b1;
      if (grant[i]) begin
        grant_id      = ID_W'(i);
        grant_is_hint = hint_ready[i];
      end
    end
  end

  ase_rr_arbiter #(.N(NUM_UMSG)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (hint_ready | data_ready),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // Registered output slot. Hints carry a zero line. With no grant the slot
  // empties on acceptance but hdr/data hold their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      umsg_valid <= 1'b0;
      umsg_hdr   <= '0;
      umsg_data  <= '0;
    end else if (|grant) begin
      umsg_valid <= 1'b1;
      umsg_hdr   <= make_umsg_hdr(6'(grant_id), grant_is_hint);
      umsg_data  <= grant_is_hint ? '0 : data_buf[grant_id];
    end else if (umsg_ready) begin
      umsg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// tb_ase_umsg_engine
// Directed scenarios followed by random traffic, compared cycle by cycle
// against a deadline-based reference model of UMsg delivery.

module tb_ase_umsg_engine;
  import ase_pkg::*;

  localparam int NUM = 8;
  localparam int H   = 4;
  localparam int D   = 8;
  localparam int DW  = 512;
  localparam int P_IDLE = 0;
  localparam int P_HINT = 1;
  localparam int P_DATA = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_id = '0;
  logic          cmd_hint = 1'b0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic          umsg_valid;
  logic [27:0]   umsg_hdr;
  logic [DW-1:0] umsg_data;
  logic          umsg_ready = 1'b1;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // Reference model: each ID is idle, owes a hint, or owes data, and becomes
  // sendable at an absolute cycle number.
  int            phase [NUM];
  longint        due   [NUM];
  logic [DW-1:0] mbuf  [NUM];
  int            last;
  logic          exp_valid;
  logic [27:0]   exp_hdr;
  logic [DW-1:0] exp_data;
  longint        cyc = 0;

  ase_umsg_engine #(
    .NUM_UMSG(NUM), .TIMER_W(4), .HINT_DELAY(H), .DATA_DELAY(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_hint(cmd_hint), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .umsg_valid(umsg_valid), .umsg_hdr(umsg_hdr), .umsg_data(umsg_data),
    .umsg_ready(umsg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelBusy();
    logic b;
    b = exp_valid;
    for (int i = 0; i < NUM; i++) if (phase[i] != P_IDLE) b = 1'b1;
    return b;
  endfunction

  task automatic checkCycle();
    checkOutput("umsg_valid", DW'(umsg_valid), DW'(exp_valid));
    checkOutput("umsg_hdr", DW'(umsg_hdr), DW'(exp_hdr));
    checkOutput("umsg_data", umsg_data, exp_data);
    checkOutput("busy", DW'(busy), DW'(modelBusy()));
    checkOutput("cmd_ready", DW'(cmd_ready), DW'(1'b1));
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM; i++) begin
      phase[i] = P_IDLE;
      due[i]   = 0;
    end
    last      = NUM - 1;
    exp_valid = 1'b0;
    exp_hdr   = '0;
    exp_data  = '0;
  endtask

  // One cycle of the model: the slot is offered first (so a same-cycle grant
  // sees the old line), then the command is applied.
  task automatic modelCycle(input logic v, input logic [2:0] id, input logic h,
                            input logic [DW-1:0] d, input logic rdy);
    int g;
    UMsgHdr_t hdr;
    g = -1;
    if (!exp_valid || rdy) begin
      for (int k = 1; k <= NUM; k++) begin
        int j;
        j = (last + k) % NUM;
        if (g < 0 && phase[j] != P_IDLE && cyc >= due[j]) g = j;
      end
      if (g >= 0) begin
        hdr           = '0;
        hdr.resp_type = 4'hF;
        hdr.umsg_id   = 6'(g);
        if (phase[g] == P_HINT) begin
          hdr.umsg_type = 1'b1;
          exp_data      = '0;
          phase[g]      = P_DATA;
          due[g]        = cyc + 2 + D;
        end else begin
          hdr.umsg_type = 1'b0;
          exp_data      = mbuf[g];
          phase[g]      = P_IDLE;
        end
        exp_hdr   = hdr;
        exp_valid = 1'b1;
        last      = g;
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (v) begin
      mbuf[id] = d;
      if (phase[id] == P_IDLE) begin
        phase[id] = h ? P_HINT : P_DATA;
        due[id]   = cyc + 2 + (h ? H : D);
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] id, input logic h,
                               input logic [DW-1:0] d, input logic rdy);
    @(negedge clk);
    checkCycle();
    cmd_valid  = v;
    cmd_id     = id;
    cmd_hint   = h;
    cmd_data   = d;
    umsg_ready = rdy;
    modelCycle(v, id, h, d, rdy);
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, '0, rdy);
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [DW-1:0] pat;
    logic tog;
    for (int i = 0; i < NUM; i++) mbuf[i] = '0;
    modelReset();

    // Reset values while held in reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", DW'(umsg_valid), '0);
    checkOutput("reset_hdr", DW'(umsg_hdr), '0);
    checkOutput("reset_data", umsg_data, '0);
    checkOutput("reset_busy", DW'(busy), '0);
    checkOutput("reset_cmd_ready", DW'(cmd_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unhinted command to ID 3
    idle(2, 1'b1);
    pat = {64{8'hA5}};
    applyStimulus(1'b1, 3'd3, 1'b0, pat, 1'b1);
    idle(16, 1'b1);

    // Hinted command to ID 5
    applyStimulus(1'b1, 3'd5, 1'b1, {64{8'h5A}}, 1'b1);
    idle(22, 1'b1);

    // Coalescing on ID 2
    applyStimulus(1'b1, 3'd2, 1'b0, {64{8'h11}}, 1'b1);
    idle(2, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b0, {64{8'h22}}, 1'b1);
    idle(16, 1'b1);

    // Contention: all IDs, ready toggling 1010...
    tog = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b0, randData(), tog);
      tog = ~tog;
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, '0, tog);
      tog = ~tog;
    end

    // Grant collision on ID 6: second command lands on its data-grant cycle
    applyStimulus(1'b1, 3'd6, 1'b0, {64{8'h66}}, 1'b1);
    idle(D + 1, 1'b1);
    applyStimulus(1'b1, 3'd6, 1'b0, {64{8'h77}}, 1'b1);
    idle(16, 1'b1);

    // Hinted collision on ID 1
    applyStimulus(1'b1, 3'd1, 1'b1, {64{8'h31}}, 1'b1);
    idle(H + 1, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b0, {64{8'h32}}, 1'b1);
    idle(24, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, NUM - 1)),
                    1'($urandom_range(0, 1)), randData(), $urandom_range(0, 3) != 0);
    end
    idle(40, 1'b1);

    // Reset mid-operation: ID 7 stuck in the slot, IDs 1 and 4 waiting
    applyStimulus(1'b1, 3'd7, 1'b0, randData(), 1'b0);
    idle(D + 4, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, randData(), 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0, randData(), 1'b0);
    idle(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", DW'(umsg_valid), '0);
    checkOutput("async_hdr", DW'(umsg_hdr), '0);
    checkOutput("async_data", umsg_data, '0);
    checkOutput("async_busy", DW'(busy), '0);
    checkOutput("async_cmd_ready", DW'(cmd_ready), '0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ase_umsg_engine.md
# ase_umsg_engine

Per-ID UMsg delivery engine in the ASE CCI-P emulator, between the DPI-side UMsg command source and the RX0 response arbiter. It accepts UMsg commands (`umsgcmd_t` semantics: id, hint flag, 512-bit line), delays them, and emits optional hint and data responses on RX0. Each UMsg ID runs its own `UMsg_StateEnum` FSM with the `umsg_t` control fields. A round-robin arbiter feeds one registered output slot.

## Interface
- `NUM_UMSG`, default 8: UMsg IDs; must equal `NUM_UMSG_PER_AFU`.
- `TIMER_W`, default `` `UMSG_DELAY_TIMER_LOG2 ``: hint and data timer width.
- `HINT_DELAY`, default 4: hint-wait cycles; must be < 2^TIMER_W.
- `DATA_DELAY`, default 8: data-wait cycles; must be < 2^TIMER_W.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_id` in $clog2(NUM_UMSG): target ID.
- `cmd_hint` in 1: request a hint before data.
- `cmd_data` in 512: UMsg line.
- `cmd_ready` out 1: always 1 outside reset; the block never stalls commands.
- `umsg_valid` out 1: RX0 UMsg response valid.
- `umsg_hdr` out 28: `UMsgHdr_t`.
- `umsg_data` out 512: line data; zero for hints.
- `umsg_ready` in 1: downstream accepts when `umsg_valid & umsg_ready`.
- `busy` out 1: any ID not in UMsgIdle, or `umsg_valid` set.

## Operation
- Storage per ID: `data_buf[id]` (512 bits) and one `umsg_t`.
- Command accept (`cmd_valid`) with ID in UMsgIdle:
  - Store data and set `line_accessed`.
  - If `cmd_hint`: set `hint_enable`, load `hint_timer=HINT_DELAY`, go to UMsgHintWait.
  - Else: load `data_timer=DATA_DELAY`, go to UMsgDataWait.
- Command accept with ID busy (coalescing): overwrite `data_buf`, set `line_accessed`, no state or timer change, no extra hint.
- UMsgHintWait: if `hint_timer==0` go to UMsgSendHint (`hint_ready=1`), else decrement.
- UMsgSendHint: on grant, `hint_pop` fires; load `data_timer=DATA_DELAY`; go to UMsgDataWait.
- UMsgDataWait: if `data_timer==0` go to UMsgSendData (`data_ready=1`), else decrement.
- UMsgSendData: on grant, `data_pop` fires; clear `line_accessed` and `hint_enable`; go to UMsgIdle.
- Arbiter:
  - Candidates are IDs in UMsgSendHint or UMsgSendData.
  - Round-robin: search starts at last granted ID + 1, modulo NUM_UMSG; pointer resets to `NUM_UMSG-1` so ID 0 wins first.
  - Grant only when the output slot is free: `!umsg_valid | umsg_ready`.
- Output header fields:
  - `resp_type=4'hF` (CCIP_UMSG), `umsg_id=id` (zero-extended to 6 bits).
  - `umsg_type=1` for hint, 0 for data.
  - `poison` and all reserved fields 0.
- Same-cycle data grant and new command for one ID: the output captures the old `data_buf`; the command is then processed as if the ID were Idle (fresh FSM start, new data stored).
- Reset: all FSMs to UMsgIdle, timers 0, flags 0, pointer to `NUM_UMSG-1`. Pending UMsgs are dropped. `data_buf` is not reset.

## Timing
- Reset values: `umsg_valid=0`, `umsg_hdr=0`, `umsg_data=0`, `busy=0`, `cmd_ready=0` during reset and 1 after.
- Hinted command accepted at cycle N with no contention:
  - HintWait from N+1, SendHint at N+2+HINT_DELAY.
  - Hint on output at N+3+HINT_DELAY.
  - Data on output at N+5+HINT_DELAY+DATA_DELAY.
- Unhinted command accepted at cycle N: data on output at N+3+DATA_DELAY.
- Output is registered. While `umsg_valid & !umsg_ready`, hdr and data stay stable and no grant occurs.
- Throughput: one response per cycle when `umsg_ready` is held high.

## Structure
- `ase_pkg` supplies `UMsgHdr_t`, `umsg_t`, `UMsg_StateEnum`, `NUM_UMSG_PER_AFU`, `CCIP_DATA_WIDTH`. Add `ASE_UMSG_HINT_DELAY` and `ASE_UMSG_DATA_DELAY` defaults there.
- Sub-module `ase_rr_arbiter` (parameter N; request vector in, one-hot grant out, grant-enable input) is reused by other RX arbiters.

## Test plan
- Unhinted: HINT_DELAY=4, DATA_DELAY=8; cmd id 3 with data 0xA5… at cycle 10 -> one data response at cycle 21 with `umsg_type=0`, `umsg_id=3`, data 0xA5…; `busy` falls at cycle 22.
- Hinted: cmd id 5 with hint at cycle 10 -> hint at cycle 17 (data 0, `umsg_type=1`), then data at cycle 27.
- Coalescing: cmd id 2 with data X, then cmd id 2 with data Y 3 cycles later -> exactly one data response, carrying Y.
- Contention: cmds for ids 0–7 in the same 8 cycles, `umsg_ready` toggling 1010… -> 8 data responses in round-robin order, none lost, hdr/data stable during stalls.
- Grant collision: new cmd for an id on the same cycle its data is granted -> old data emitted, then a second full sequence with the new data.
- Reset mid-operation: assert `rst_n=0` with ids 1 and 4 in DataWait and `umsg_valid=1` -> all outputs 0 immediately (asynchronously); no responses after release.
